enigma_in_stage: RTL and testbench

//  Input conditioning and load sequencer directly upstream of the rotor table registers (rotorA/B/C).

---
 rtl/enigma_pkg.sv | 19 +
 rtl/enigma_tbl_counter.sv | 31 +++
 rtl/enigma_in_stage.sv | 125 ++++++++++++
 tb/tb_enigma_in_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared constants and types for the Enigma input stage: table indices,
// table geometry and the load/run phase encoding.
package enigma_pkg;

  localparam int DEPTH      = 64;
  localparam int CODE_W     = 6;
  localparam int NUM_TABLES = 3;

  localparam logic [1:0] TBL_A   = 2'd0;
  localparam logic [1:0] TBL_B   = 2'd1;
  localparam logic [1:0] TBL_C   = 2'd2;
  localparam logic [1:0] TBL_BAD = 2'd3;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/enigma_tbl_counter.sv
// Per-table load-word counter. Saturates at DEPTH and raises a registered
// full flag on the same edge that the DEPTH-th word is counted.
module enigma_tbl_counter
  import enigma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [CODE_W:0]   cnt,
  output logic              full
);

  logic [CODE_W:0] cnt_reg;
  logic            full_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg  <= '0;
      full_reg <= 1'b0;
    end else if (inc && !full_reg) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (cnt_reg == (CODE_W+1)'(DEPTH - 1))
        full_reg <= 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign full = full_reg;

endmodule

// File: rtl/enigma_in_stage.sv
// Input conditioning and load sequencer ahead of the rotor tables: buffers
// host words, counts table loads, and steps the rotor counter in the run phase.
module enigma_in_stage
  import enigma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              load,
  input  logic [1:0]        table_idx,
  input  logic [CODE_W-1:0] code_in,
  input  logic              clr,
  output logic [1:0]        table_idx_buf,
  output logic              load_buf,
  output logic [CODE_W-1:0] code_in_buf,
  output logic              crypt_valid_buf,
  output logic [2:0]        tables_loaded,
  output logic              ready,
  output logic [CODE_W-1:0] step_cnt,
  output logic              step_wrap,
  output logic              err
);

  state_t state_reg, state_next;

  logic [CODE_W:0]         tbl_cnt [NUM_TABLES];
  logic [NUM_TABLES-1:0]   tbl_full;
  logic [NUM_TABLES-1:0]   tbl_inc;
  logic [NUM_TABLES-1:0]   will_full;
  logic [3:0]              slot_full;

  logic load_acc, crypt_acc, rejected;

  logic [1:0]        table_idx_buf_reg;
  logic [CODE_W-1:0] code_in_buf_reg;
  logic              load_buf_reg;
  logic              crypt_valid_buf_reg;
  logic              ready_reg;
  logic [CODE_W-1:0] step_cnt_reg;
  logic              step_wrap_reg;
  logic              err_reg;

  // The illegal index maps onto a permanently "full" slot so it is rejected
  // by the same check as a load into a filled table.
  assign slot_full = {1'b1, tbl_full};

  always_comb begin
    load_acc  = in_valid & ~clr & load & ~slot_full[table_idx];
    crypt_acc = in_valid & ~clr & ~load & (state_reg == RUN);
    rejected  = in_valid & ~clr & ~load_acc & ~crypt_acc;
  end

  generate
    for (genvar gi = 0; gi < NUM_TABLES; gi++) begin : g_tbl
      assign tbl_inc[gi]   = load_acc && (table_idx == 2'(gi));
      assign will_full[gi] = tbl_full[gi] |
                             (tbl_inc[gi] && (tbl_cnt[gi] == (CODE_W+1)'(DEPTH - 1)));

      enigma_tbl_counter u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (tbl_inc[gi]),
        .cnt  (tbl_cnt[gi]),
        .full (tbl_full[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    if (clr)
      state_next = LOAD;
    else if (state_reg == LOAD && (&will_full))
      state_next = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= LOAD;
      table_idx_buf_reg   <= '0;
      code_in_buf_reg     <= '0;
      load_buf_reg        <= 1'b0;
      crypt_valid_buf_reg <= 1'b0;
      ready_reg           <= 1'b0;
      step_cnt_reg        <= '0;
      step_wrap_reg       <= 1'b0;
      err_reg             <= 1'b0;
    end else begin
      state_reg           <= state_next;
      ready_reg           <= (state_next == RUN);
      load_buf_reg        <= load_acc;
      crypt_valid_buf_reg <= crypt_acc;
      step_wrap_reg       <= crypt_acc && (step_cnt_reg == CODE_W'(DEPTH - 1));

      if (load_acc) begin
        table_idx_buf_reg <= table_idx;
        code_in_buf_reg   <= code_in;
      end else if (crypt_acc) begin
        code_in_buf_reg   <= code_in;
      end

      if (clr)
        step_cnt_reg <= '0;
      else if (crypt_acc)
        step_cnt_reg <= step_cnt_reg + 1'b1;

      if (clr)
        err_reg <= 1'b0;
      else if (rejected)
        err_reg <= 1'b1;
    end
  end

  assign table_idx_buf   = table_idx_buf_reg;
  assign code_in_buf     = code_in_buf_reg;
  assign load_buf        = load_buf_reg;
  assign crypt_valid_buf = crypt_valid_buf_reg;
  assign tables_loaded   = tbl_full;
  assign ready           = ready_reg;
  assign step_cnt        = step_cnt_reg;
  assign step_wrap       = step_wrap_reg;
  assign err             = err_reg;

endmodule

// File: tb/tb_enigma_in_stage.sv
// Bench for enigma_in_stage: directed phases plus a randomized mix, each cycle
// checked against a word-level model of loads, crypt words, clr and rst.
module tb_enigma_in_stage;

  logic       clk = 1'b0;
  logic       rst, in_valid, load, clr;
  logic [1:0] table_idx;
  logic [5:0] code_in;
  logic [1:0] table_idx_buf;
  logic       load_buf, crypt_valid_buf, ready, step_wrap, err;
  logic [5:0] code_in_buf, step_cnt;
  logic [2:0] tables_loaded;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  int m_cnt [3];
  int m_run, m_step, m_err, m_lbuf, m_cbuf, m_wrap, m_idxbuf, m_codebuf;
  int wraps_seen;

  always #5 clk = ~clk;

  enigma_in_stage dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .load            (load),
    .table_idx       (table_idx),
    .code_in         (code_in),
    .clr             (clr),
    .table_idx_buf   (table_idx_buf),
    .load_buf        (load_buf),
    .code_in_buf     (code_in_buf),
    .crypt_valid_buf (crypt_valid_buf),
    .tables_loaded   (tables_loaded),
    .ready           (ready),
    .step_cnt        (step_cnt),
    .step_wrap       (step_wrap),
    .err             (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int loaded_bits();
    int b = 0;
    for (int i = 0; i < 3; i++)
      if (m_cnt[i] == 64) b |= (1 << i);
    return b;
  endfunction

  // Apply one cycle of inputs, advance the model by the word-level rules,
  // then compare every output just after the edge.
  task automatic cycle(input int r, input int c, input int v, input int ld,
                       input int idx, input int code);
    rst = r[0]; clr = c[0]; in_valid = v[0]; load = ld[0];
    table_idx = idx[1:0]; code_in = code[5:0];
    m_lbuf = 0; m_cbuf = 0; m_wrap = 0;
    if (r != 0) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_run = 0; m_step = 0; m_err = 0; m_idxbuf = 0; m_codebuf = 0;
    end else if (c != 0) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_run = 0; m_step = 0; m_err = 0;
    end else if (v != 0) begin
      if (ld != 0) begin
        if (idx < 3 && m_cnt[idx] < 64) begin
          m_cnt[idx]++;
          m_lbuf = 1; m_idxbuf = idx; m_codebuf = code;
          if (loaded_bits() == 7) m_run = 1;
        end else m_err = 1;
      end else if (m_run != 0) begin
        m_cbuf = 1; m_codebuf = code;
        m_wrap = (m_step == 63) ? 1 : 0;
        m_step = (m_step + 1) % 64;
      end else m_err = 1;
    end
    @(posedge clk);
    #1;
    if (step_wrap === 1'b1) wraps_seen++;
    $display("cyc rst=%0d clr=%0d v=%0d ld=%0d idx=%0d code=%0d -> lb=%0d cv=%0d idxb=%0d codeb=%0d tl=%b rdy=%0d step=%0d wrap=%0d err=%0d",
             r, c, v, ld, idx, code, load_buf, crypt_valid_buf, table_idx_buf,
             code_in_buf, tables_loaded, ready, step_cnt, step_wrap, err);
    check("load_buf",        32'(load_buf),        32'(m_lbuf));
    check("crypt_valid_buf", 32'(crypt_valid_buf), 32'(m_cbuf));
    check("table_idx_buf",   32'(table_idx_buf),   32'(m_idxbuf));
    check("code_in_buf",     32'(code_in_buf),     32'(m_codebuf));
    check("tables_loaded",   32'(tables_loaded),   32'(loaded_bits()));
    check("ready",           32'(ready),           32'(m_run));
    check("step_cnt",        32'(step_cnt),        32'(m_step));
    check("step_wrap",       32'(step_wrap),       32'(m_wrap));
    check("err",             32'(err),             32'(m_err));
  endtask

  task automatic load_table(input int idx, input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 1, 1, idx, int'($urandom_range(63)));
  endtask

  initial begin
    int ld, idx;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; load = 1'b0;
    table_idx = 2'd0; code_in = 6'd0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_run = 0; m_step = 0; m_err = 0; m_idxbuf = 0; m_codebuf = 0;
    wraps_seen = 0;

    // reset state
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 1, 5);
    check("reset_ready", 32'(ready), 32'd0);

    // phase 1: table B with codes 0..63
    for (int i = 0; i < 64; i++) cycle(0, 0, 1, 1, 1, i);
    check("p1_tables_loaded", 32'(tables_loaded), 32'b010);
    check("p1_ready", 32'(ready), 32'd0);
    check("p1_err", 32'(err), 32'd0);

    // phase 2: A and C complete the load; 65th word to B is rejected
    load_table(0, 64);
    load_table(2, 63);
    check("p2_not_ready_yet", 32'(ready), 32'd0);
    load_table(2, 1);
    check("p2_ready", 32'(ready), 32'd1);
    check("p2_tables_loaded", 32'(tables_loaded), 32'b111);
    cycle(0, 0, 1, 1, 1, 7);
    check("p2_overflow_err", 32'(err), 32'd1);
    check("p2_overflow_no_pulse", 32'(load_buf), 32'd0);

    // phase 3: 130 crypt words
    wraps_seen = 0;
    for (int i = 0; i < 130; i++) cycle(0, 0, 1, 0, 0, int'($urandom_range(63)));
    check("p3_wraps", 32'(wraps_seen), 32'd2);
    check("p3_step_cnt", 32'(step_cnt), 32'd2);
    cycle(0, 0, 0, 0, 0, 0);

    // phase 4: crypt word in LOAD, then illegal table index
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 9);
    check("p4_crypt_in_load_err", 32'(err), 32'd1);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 3, 11);
    check("p4_bad_idx_err", 32'(err), 32'd1);

    // phase 5: clr alongside a valid load word with B at 10
    cycle(0, 1, 0, 0, 0, 0);
    load_table(1, 10);
    cycle(0, 1, 1, 1, 1, 33);
    check("p5_clr_no_load_buf", 32'(load_buf), 32'd0);
    check("p5_clr_err", 32'(err), 32'd0);
    load_table(1, 64);
    check("p5_b_full_after_64", 32'(tables_loaded), 32'b010);

    // randomized mix with occasional clr and bad indices
    cycle(0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 800; n++) begin
      ld  = (m_run != 0) ? int'($urandom_range(7) == 0) : int'($urandom_range(7) != 0);
      idx = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
      cycle(0, int'($urandom_range(399) == 0), int'($urandom_range(3) != 0),
            ld, idx, int'($urandom_range(63)));
    end

    // phase 6: rst during RUN
    cycle(0, 1, 0, 0, 0, 0);
    load_table(0, 64); load_table(1, 64); load_table(2, 64);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0, int'($urandom_range(63)));
    check("p6_in_run", 32'(ready), 32'd1);
    cycle(1, 0, 1, 0, 0, 17);
    check("p6_rst_step", 32'(step_cnt), 32'd0);
    cycle(0, 0, 1, 0, 0, 21);
    check("p6_crypt_rejected", 32'(crypt_valid_buf), 32'd0);
    check("p6_err", 32'(err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
